// File: rtl/board_pkg.sv
// Shared board definitions: cell encodings, address layout and placer state encoding.
package board_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned ADR_W = ROW_W + COL_W;

  localparam logic [7:0]  CELL_EMPTY = 8'h00;
  localparam logic [7:0]  CELL_MINE  = 8'h80;
  localparam int unsigned MINE_BIT   = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GEN,
    S_RD,
    S_CHK,
    S_WR,
    S_FINISH
  } placer_state_t;

  function automatic logic [ADR_W-1:0] adr_pack(input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [ROW_W-1:0] adr_row(input logic [ADR_W-1:0] adr);
    return adr[ADR_W-1 -: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] adr_col(input logic [ADR_W-1:0] adr);
    return adr[COL_W-1:0];
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bundle shared by the board memory and its masters.
interface wishbone_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          stall_i;
  logic          ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, stall_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, stall_i, ack_i
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; a zero seed is replaced by 8'h01.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  logic fb;

  assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'h01;
    end else if (load) begin
      value <= (seed == '0) ? 8'h01 : seed;
    end else if (step) begin
      value <= {value[6:0], fb};
    end
  end

endmodule

// File: rtl/board_mine_placer.sv
// Clears the active board region, then places distinct pseudo-random mines via
// separate Wishbone write and read masters.
module board_mine_placer
  import board_pkg::*;
#(
  parameter int unsigned MAX_SIZE = 16,
  parameter int unsigned DW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] board_size,
  input  logic [7:0] mine_count,
  input  logic [7:0] seed,
  wishbone_if.master master_wr,
  wishbone_if.master master_rd,
  output logic       busy,
  output logic       done
);

  placer_state_t    state, state_nxt;
  logic [4:0]       size_q;
  logic [7:0]       mines_q;
  logic [7:0]       placed;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [7:0]       cand;
  logic             rd_mine;
  logic             rd_acc;
  logic [7:0]       lfsr_val;

  logic [4:0]       size_clamped;
  logic [9:0]       mine_limit;
  logic [7:0]       mines_clamped;
  logic [7:0]       cand_cur;
  logic             in_range;
  logic             wr_accept;
  logic             rd_accept;
  logic             last_col;
  logic             last_row;
  logic             placed_last;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (state == S_IDLE && start),
    .seed  (seed),
    .step  (state == S_GEN),
    .value (lfsr_val)
  );

  // At least one cell of the active region always stays mine-free.
  always_comb begin
    size_clamped = board_size;
    if (board_size == '0) begin
      size_clamped = 5'd1;
    end else if (board_size > 5'(MAX_SIZE)) begin
      size_clamped = 5'(MAX_SIZE);
    end
    mine_limit    = ({5'b0, size_clamped} * {5'b0, size_clamped}) - 10'd1;
    mines_clamped = ({2'b0, mine_count} > mine_limit) ? mine_limit[7:0] : mine_count;
  end

  assign cand_cur    = lfsr_val ^ 8'hFF;
  assign in_range    = ({1'b0, adr_row(cand_cur)} < size_q) && ({1'b0, adr_col(cand_cur)} < size_q);
  assign wr_accept   = (state == S_CLEAR || state == S_WR) && !master_wr.stall_i;
  assign rd_accept   = (state == S_RD) && !rd_acc && !master_rd.stall_i;
  assign last_col    = ({1'b0, col} == size_q - 5'd1);
  assign last_row    = ({1'b0, row} == size_q - 5'd1);
  assign placed_last = (placed + 8'd1 == mines_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  if (wr_accept && last_col && last_row)
                  state_nxt = (mines_q != '0) ? S_GEN : S_FINISH;
      S_GEN:    if (in_range) state_nxt = S_RD;
      S_RD:     if (master_rd.ack_i) state_nxt = S_CHK;
      S_CHK:    state_nxt = rd_mine ? S_GEN : S_WR;
      S_WR:     if (wr_accept) state_nxt = placed_last ? S_FINISH : S_GEN;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q  <= 5'd1;
      mines_q <= '0;
      placed  <= '0;
      row     <= '0;
      col     <= '0;
      cand    <= '0;
      rd_mine <= 1'b0;
      rd_acc  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          size_q  <= size_clamped;
          mines_q <= mines_clamped;
          placed  <= '0;
          row     <= '0;
          col     <= '0;
        end
        S_CLEAR: if (wr_accept) begin
          if (last_col) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_GEN: begin
          cand   <= cand_cur;
          rd_acc <= 1'b0;
        end
        S_RD: begin
          if (rd_accept) rd_acc <= 1'b1;
          if (master_rd.ack_i) rd_mine <= master_rd.dat_i[MINE_BIT];
        end
        S_WR: if (wr_accept) placed <= placed + 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode the state only, so reset drops every strobe asynchronously.
  always_comb begin
    master_wr.cyc_o = 1'b0;
    master_wr.stb_o = 1'b0;
    master_wr.we_o  = 1'b0;
    master_wr.adr_o = '0;
    master_wr.dat_o = '0;
    master_rd.cyc_o = 1'b0;
    master_rd.stb_o = 1'b0;
    master_rd.we_o  = 1'b0;
    master_rd.adr_o = '0;
    master_rd.dat_o = '0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      S_CLEAR: begin
        master_wr.cyc_o = 1'b1;
        master_wr.stb_o = 1'b1;
        master_wr.we_o  = 1'b1;
        master_wr.adr_o = adr_pack(row, col);
        master_wr.dat_o = DW'(CELL_EMPTY);
        busy            = 1'b1;
      end
      S_WR: begin
        master_wr.cyc_o = 1'b1;
        master_wr.stb_o = 1'b1;
        master_wr.we_o  = 1'b1;
        master_wr.adr_o = cand;
        master_wr.dat_o = DW'(CELL_MINE);
        busy            = 1'b1;
      end
      S_RD: begin
        master_rd.cyc_o = 1'b1;
        master_rd.stb_o = !rd_acc;
        master_rd.adr_o = cand;
        busy            = 1'b1;
      end
      S_GEN, S_CHK: busy = 1'b1;
      S_FINISH:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_mine_placer.sv
// Bench for board_mine_placer: behavioural board memory plus write scoreboard.
module tb_board_mine_placer;
  import board_pkg::*;

  typedef struct packed {
    logic [7:0] adr;
    logic [7:0] dat;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] board_size;
  logic [7:0] mine_count;
  logic [7:0] seed;
  logic       busy;
  logic       done;

  wishbone_if #(.AW(8), .DW(8)) wr_bus ();
  wishbone_if #(.AW(8), .DW(8)) rd_bus ();

  board_mine_placer #(.MAX_SIZE(16), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_size (board_size),
    .mine_count (mine_count),
    .seed       (seed),
    .master_wr  (wr_bus),
    .master_rd  (rd_bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  wr_t        exp_q[$];
  wr_t        obs_q[$];
  int         obs_rd = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc_cnt = 0;
  int         done_cnt = 0;
  int         mine_wr_cnt = 0;
  int         both_strobe = 0;
  int         t_busy = 0;
  int         t_done = 0;
  logic       busy_d = 1'b0;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_pend_adr = 8'h00;
  logic       fill_req = 1'b0;
  logic [7:0] fill_val = 8'h00;

  // Memory/slave model, sampled mid-cycle; read ack arrives the cycle after acceptance.
  always @(negedge clk) begin
    cyc_cnt++;
    wr_bus.ack_i = 1'b0;
    wr_bus.dat_i = 8'h00;
    if (fill_req) for (int i = 0; i < 256; i++) mem[i] = fill_val;
    if (rst) begin
      rd_bus.ack_i = 1'b0;
      rd_bus.dat_i = 8'h00;
      rd_pend      = 1'b0;
      busy_d       = 1'b0;
    end else begin
      rd_bus.ack_i = rd_pend;
      rd_bus.dat_i = mem[rd_pend_adr];
      rd_pend      = 1'b0;
      if (rd_bus.cyc_o && rd_bus.stb_o && !rd_bus.stall_i) begin
        rd_pend     = 1'b1;
        rd_pend_adr = rd_bus.adr_o;
      end
      if (wr_bus.cyc_o && wr_bus.stb_o && wr_bus.we_o && !wr_bus.stall_i) begin
        mem[wr_bus.adr_o] = wr_bus.dat_o;
        obs_q.push_back({wr_bus.adr_o, wr_bus.dat_o});
        if (wr_bus.dat_o == CELL_MINE) mine_wr_cnt++;
      end
      if (wr_bus.stb_o && rd_bus.stb_o) both_strobe++;
      if (busy && !busy_d) t_busy = cyc_cnt;
      if (done) begin
        done_cnt++;
        t_done = cyc_cnt;
      end
      busy_d = busy;
    end
  end

  task automatic fill_mem(input logic [7:0] v);
    fill_val = v;
    fill_req = 1'b1;
    @(negedge clk);
    #1 fill_req = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] sz, input logic [7:0] cnt, input logic [7:0] sd);
    @(posedge clk);
    #1;
    board_size = sz;
    mine_count = cnt;
    seed       = sd;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      #1 k++;
    end
    ok = (done_cnt != d0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input int sz);
    logic [7:0] a;
    for (int r = 0; r < sz; r++)
      for (int c = 0; c < sz; c++) begin
        a = {r[3:0], c[3:0]};
        exp_q.push_back({a, CELL_EMPTY});
      end
  endtask

  // Reference placement: clamp inputs, walk the LFSR, keep in-range first visits.
  task automatic push_mines(input int bsz, input int cnt, input logic [7:0] sd);
    int         sz, m, p, guard;
    logic [7:0] l, c;
    bit         taken [256];
    sz = (bsz == 0) ? 1 : (bsz > 16 ? 16 : bsz);
    m  = (cnt > sz * sz - 1) ? sz * sz - 1 : cnt;
    l  = (sd == 8'h00) ? 8'h01 : sd;
    p  = 0;
    guard = 0;
    for (int i = 0; i < 256; i++) taken[i] = 1'b0;
    while (p < m && guard < 5000) begin
      c = l ^ 8'hFF;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      if (int'(c[7:4]) < sz && int'(c[3:0]) < sz && !taken[c]) begin
        taken[c] = 1'b1;
        exp_q.push_back({c, CELL_MINE});
        p++;
      end
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({wr_bus.cyc_o, wr_bus.stb_o, wr_bus.we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_wr_ctl: got %b want 000", {wr_bus.cyc_o, wr_bus.stb_o, wr_bus.we_o}); end
    n_checks++; if ({rd_bus.cyc_o, rd_bus.stb_o, rd_bus.we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_rd_ctl: got %b want 000", {rd_bus.cyc_o, rd_bus.stb_o, rd_bus.we_o}); end
    n_checks++; if ({wr_bus.adr_o, wr_bus.dat_o, rd_bus.adr_o} !== 24'h0) begin n_fail++; $display("FAIL reset_adr_dat: got %h want 000000", {wr_bus.adr_o, wr_bus.dat_o, rd_bus.adr_o}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_clear_only();
    bit  ok;
    int  d0;
    wr_t e, o;
    fill_mem(8'hAA);
    exp_q.delete(); obs_rd = obs_q.size(); d0 = done_cnt;
    push_clear(4);
    start_run(5'd4, 8'd0, 8'h3C);
    wait_done(d0, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clear_timeout: got no done want done"); end
    n_checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin n_fail++; $display("FAIL clear_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL clear_write: got %h/%h want %h/%h", o.adr, o.dat, e.adr, e.dat); end
    end
    n_checks++; if (t_done - t_busy !== 16) begin n_fail++; $display("FAIL clear_latency: got %0d want 16", t_done - t_busy); end
    n_checks++; if (mem[8'h44] !== 8'hAA) begin n_fail++; $display("FAIL clear_outside: got %h want aa", mem[8'h44]); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL clear_done_pulses: got %0d want 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_mines();
    bit  ok;
    int  d0, b0, n_in, n_out;
    wr_t e, o;
    fill_mem(8'hAA);
    exp_q.delete(); obs_rd = obs_q.size(); d0 = done_cnt; b0 = both_strobe;
    push_clear(8);
    push_mines(8, 10, 8'h5A);
    start_run(5'd8, 8'd10, 8'h5A);
    repeat (5) @(posedge clk);
    #1 start_run(5'd16, 8'd3, 8'h11);
    wait_done(d0, 3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mines_timeout: got no done want done"); end
    n_checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin n_fail++; $display("FAIL mines_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL mines_write: got %h/%h want %h/%h", o.adr, o.dat, e.adr, e.dat); end
    end
    n_in = 0; n_out = 0;
    for (int a = 0; a < 256; a++) begin
      if ((a >> 4) < 8 && (a & 15) < 8) begin if (mem[a] == CELL_MINE) n_in++; end
      else if (mem[a] != 8'hAA) n_out++;
    end
    n_checks++; if (n_in !== 10) begin n_fail++; $display("FAIL mines_in_region: got %0d want 10", n_in); end
    n_checks++; if (n_out !== 0) begin n_fail++; $display("FAIL mines_outside_touched: got %0d want 0", n_out); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL mines_done_pulses: got %0d want 1", done_cnt - d0); end
    n_checks++; if (both_strobe - b0 !== 0) begin n_fail++; $display("FAIL mines_dual_strobe: got %0d want 0", both_strobe - b0); end
  endtask

  task automatic test_saturate();
    bit  ok;
    int  d0, n_m, n_e;
    wr_t e, o;
    fill_mem(8'hAA);
    exp_q.delete(); obs_rd = obs_q.size(); d0 = done_cnt;
    push_clear(4);
    push_mines(4, 200, 8'h00);
    start_run(5'd4, 8'd200, 8'h00);
    wait_done(d0, 3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got no done want done"); end
    n_checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL sat_write: got %h/%h want %h/%h", o.adr, o.dat, e.adr, e.dat); end
    end
    n_m = 0; n_e = 0;
    for (int a = 0; a < 256; a++)
      if ((a >> 4) < 4 && (a & 15) < 4) begin
        if (mem[a] == CELL_MINE) n_m++;
        if (mem[a] == CELL_EMPTY) n_e++;
      end
    n_checks++; if (n_m !== 15) begin n_fail++; $display("FAIL sat_mines: got %0d want 15", n_m); end
    n_checks++; if (n_e !== 1) begin n_fail++; $display("FAIL sat_empty: got %0d want 1", n_e); end
  endtask

  task automatic test_clamp();
    bit  ok;
    int  d0;
    wr_t e, o;
    exp_q.delete(); obs_rd = obs_q.size(); d0 = done_cnt;
    push_clear(1);
    push_mines(0, 5, 8'h21);
    start_run(5'd0, 8'd5, 8'h21);
    wait_done(d0, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_min_timeout: got no done want done"); end
    n_checks++; if (t_done - t_busy !== 1) begin n_fail++; $display("FAIL clamp_min_latency: got %0d want 1", t_done - t_busy); end
    push_clear(16);
    push_mines(20, 0, 8'h21);
    d0 = done_cnt;
    start_run(5'd20, 8'd0, 8'h21);
    wait_done(d0, 600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_max_timeout: got no done want done"); end
    n_checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin n_fail++; $display("FAIL clamp_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL clamp_write: got %h/%h want %h/%h", o.adr, o.dat, e.adr, e.dat); end
    end
  endtask

  task automatic test_stall();
    bit         ok;
    int         d0, k;
    logic [7:0] adr_h, dat_h;
    wr_t        e, o;
    fill_mem(8'hAA);
    exp_q.delete(); obs_rd = obs_q.size(); d0 = done_cnt;
    push_clear(4);
    start_run(5'd4, 8'd0, 8'h77);
    k = 0;
    while (obs_q.size() - obs_rd < 5 && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    n_checks++; if (obs_q.size() - obs_rd < 5) begin n_fail++; $display("FAIL stall_setup: got %0d writes want 5", obs_q.size() - obs_rd); end
    wr_bus.stall_i = 1'b1;
    adr_h = wr_bus.adr_o; dat_h = wr_bus.dat_o;
    repeat (5) begin
      @(posedge clk);
      #1;
      n_checks++; if ({wr_bus.adr_o, wr_bus.dat_o} !== {adr_h, dat_h}) begin n_fail++; $display("FAIL stall_hold: got %h/%h want %h/%h", wr_bus.adr_o, wr_bus.dat_o, adr_h, dat_h); end
    end
    wr_bus.stall_i = 1'b0;
    wait_done(d0, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
    n_checks++; if (t_done - t_busy !== 21) begin n_fail++; $display("FAIL stall_latency: got %0d want 21", t_done - t_busy); end
    n_checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL stall_write: got %h/%h want %h/%h", o.adr, o.dat, e.adr, e.dat); end
    end
  endtask

  task automatic test_reset_mid();
    bit  ok;
    int  d0, m0, k;
    wr_t e, o;
    fill_mem(8'hAA);
    m0 = mine_wr_cnt;
    start_run(5'd8, 8'd10, 8'h5A);
    k = 0;
    while (mine_wr_cnt - m0 < 2 && k < 2000) begin
      @(posedge clk);
      #1 k++;
    end
    n_checks++; if (mine_wr_cnt - m0 < 2) begin n_fail++; $display("FAIL rstmid_setup: got %0d mines want 2", mine_wr_cnt - m0); end
    rst = 1'b1;
    #1;
    n_checks++; if ({wr_bus.cyc_o, wr_bus.stb_o, rd_bus.cyc_o, rd_bus.stb_o} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_cyc: got %b want 0000", {wr_bus.cyc_o, wr_bus.stb_o, rd_bus.cyc_o, rd_bus.stb_o}); end
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy: got %b want 00", {busy, done}); end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); obs_rd = obs_q.size(); d0 = done_cnt;
    push_clear(2);
    push_mines(2, 3, 8'h81);
    start_run(5'd2, 8'd3, 8'h81);
    wait_done(d0, 2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_restart_timeout: got no done want done"); end
    n_checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_write: got %h/%h want %h/%h", o.adr, o.dat, e.adr, e.dat); end
    end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rstmid_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    board_size     = '0;
    mine_count     = '0;
    seed           = '0;
    wr_bus.stall_i = 1'b0;
    rd_bus.stall_i = 1'b0;
    test_reset();
    test_clear_only();
    test_mines();
    test_saturate();
    test_clamp();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
